// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC
// and the fetch FSM state encoding.
package if_fetch_pkg;

   localparam int RegBus      = 32;
   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache, one word per line: combinational lookup,
// one synchronous write port, valid bits cleared only by reset.
module icache_dm
   import if_fetch_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [InstAddrBus-1:0] rdAddr_i,
   output logic                   hit_o,
   output logic [InstBus-1:0]     rdData_o,
   input  logic                   wrEn_i,
   input  logic [InstAddrBus-1:0] wrAddr_i,
   input  logic [InstBus-1:0]     wrData_i
);

   localparam int Lines = 1 << IDX_W;
   localparam int TagW  = InstAddrBus - IDX_W - 2;

   logic [TagW-1:0]    tag_q  [Lines];
   logic [InstBus-1:0] data_q [Lines];
   logic [Lines-1:0]   valid_q;

   logic [IDX_W-1:0] rdIdx;
   logic [IDX_W-1:0] wrIdx;
   logic [TagW-1:0]  rdTag;
   logic [TagW-1:0]  wrTag;
   logic             unusedLow;

   // Byte-offset bits never take part in index or tag.
   assign rdIdx     = rdAddr_i[IDX_W+1:2];
   assign wrIdx     = wrAddr_i[IDX_W+1:2];
   assign rdTag     = rdAddr_i[InstAddrBus-1:IDX_W+2];
   assign wrTag     = wrAddr_i[InstAddrBus-1:IDX_W+2];
   assign unusedLow = ^{rdAddr_i[1:0], wrAddr_i[1:0]};

   assign hit_o    = valid_q[rdIdx] && (tag_q[rdIdx] == rdTag);
   assign rdData_o = data_q[rdIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wrEn_i) begin
         valid_q[wrIdx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         tag_q[wrIdx]  <= wrTag;
         data_q[wrIdx] <= wrData_i;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch initiator: owns the PC and the I-cache, requests missing
// words from the memory controller and hands instructions to IF/ID.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int                     IDX_W    = 4,
   parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_in,
   input  logic                   jump_in,
   input  logic [InstAddrBus-1:0] jump_addr_in,
   input  logic                   mem_busy,
   input  logic                   mem_take_if,
   input  logic                   get_inst,
   input  logic [InstAddrBus-1:0] inst_pc_in,
   input  logic [InstBus-1:0]     inst_in,
   output logic                   if_req,
   output logic [InstAddrBus-1:0] if_addr,
   output logic                   inst_flush,
   output logic                   if_valid,
   output logic [InstAddrBus-1:0] if_pc,
   output logic [InstBus-1:0]     if_inst
);

   fetch_state_e             state_q;
   logic [InstAddrBus-1:0]   pc_q;
   logic [InstBus-1:0]       hold_q;
   logic                     ifReq_q;
   logic [InstAddrBus-1:0]   ifAddr_q;
   logic                     instFlush_q;
   logic                     ifValid_q;
   logic [InstAddrBus-1:0]   ifPc_q;
   logic [InstBus-1:0]       ifInst_q;

   logic                     cacheHit;
   logic [InstBus-1:0]       cacheData;
   logic                     respOk;
   logic                     deliver_d;
   logic [InstBus-1:0]       deliverWord_d;
   logic                     unusedBits;

   // mem_busy only delays mem_take_if, which is all this side needs to watch.
   assign unusedBits = ^{mem_busy, inst_pc_in[1:0]};

   // The PC match filters out the stale get_inst level of the previous fetch.
   assign respOk = (state_q == WAIT) && get_inst &&
                   (inst_pc_in[InstAddrBus-1:2] == pc_q[InstAddrBus-1:2]);

   icache_dm #(.IDX_W(IDX_W)) u_icache (
      .clk      (clk),
      .rst      (rst),
      .rdAddr_i (pc_q),
      .hit_o    (cacheHit),
      .rdData_o (cacheData),
      .wrEn_i   (respOk),
      .wrAddr_i (pc_q),
      .wrData_i (inst_in)
   );

   always_comb begin
      deliver_d     = 1'b0;
      deliverWord_d = cacheData;
      if (!jump_in && !stall_in) begin
         unique case (state_q)
            IDLE: deliver_d = cacheHit;
            WAIT: begin
               deliver_d     = respOk;
               deliverWord_d = inst_in;
            end
            HOLD: begin
               deliver_d     = 1'b1;
               deliverWord_d = hold_q;
            end
            default: deliver_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         hold_q      <= '0;
         ifReq_q     <= 1'b0;
         ifAddr_q    <= '0;
         instFlush_q <= 1'b0;
         ifValid_q   <= 1'b0;
         ifPc_q      <= '0;
         ifInst_q    <= '0;
      end else begin
         instFlush_q <= 1'b0;
         ifValid_q   <= deliver_d;
         unique case (state_q)
            IDLE: begin
               if (jump_in) begin
                  pc_q <= jump_addr_in;
               end else if (!cacheHit) begin
                  state_q  <= REQ;
                  ifReq_q  <= 1'b1;
                  ifAddr_q <= pc_q;
               end
            end
            REQ: begin
               if (jump_in) begin
                  ifReq_q     <= 1'b0;
                  pc_q        <= jump_addr_in;
                  state_q     <= IDLE;
                  instFlush_q <= mem_take_if;
               end else if (mem_take_if) begin
                  ifReq_q <= 1'b0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (jump_in) begin
                  instFlush_q <= 1'b1;
                  pc_q        <= jump_addr_in;
                  state_q     <= IDLE;
               end else if (respOk && stall_in) begin
                  hold_q  <= inst_in;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (jump_in) begin
                  pc_q    <= jump_addr_in;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (deliver_d) begin
            ifPc_q   <= pc_q;
            ifInst_q <= deliverWord_d;
            pc_q     <= pc_q + 32'd4;
            state_q  <= IDLE;
         end
      end
   end

   assign if_req     = ifReq_q;
   assign if_addr    = ifAddr_q;
   assign inst_flush = instFlush_q;
   assign if_valid   = ifValid_q;
   assign if_pc      = ifPc_q;
   assign if_inst    = ifInst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: a memory-controller model drives the fetch
// handshake and a scoreboard checks the delivered instruction stream.
module tb_if_fetch;
   import if_fetch_pkg::*;

   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        jump_in = 1'b0;
   logic [31:0] jump_addr_in = '0;
   logic        mem_busy = 1'b0;
   logic        mem_take_if = 1'b0;
   logic        get_inst = 1'b0;
   logic [31:0] inst_pc_in = '0;
   logic [31:0] inst_in = '0;
   logic        if_req;
   logic [31:0] if_addr;
   logic        inst_flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic        rstEv;
      logic        jump;
      logic [31:0] target;
      logic        stall;
      logic        expFlush;
   } CycleRec;

   CycleRec recQ[$];

   if_fetch #(.IDX_W(4), .RESET_PC(ResetPc)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_in     (stall_in),
      .jump_in      (jump_in),
      .jump_addr_in (jump_addr_in),
      .mem_busy     (mem_busy),
      .mem_take_if  (mem_take_if),
      .get_inst     (get_inst),
      .inst_pc_in   (inst_pc_in),
      .inst_in      (inst_in),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .inst_flush   (inst_flush),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst)
   );

   always #5 clk = ~clk;

   // Memory contents: a bijective function of the address, so every word differs.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Memory-controller model state and the bench's view of the outstanding fetch.
   int          takeDelay = 0;
   logic        reqSeen = 1'b0;
   int          respCnt = 0;
   int          staleCnt = 0;
   logic [31:0] respAddr = '0;
   logic        outstanding = 1'b0;
   logic [31:0] outAddr = '0;

   task automatic applyStimulus(input logic doJump, input logic [31:0] target,
                                input logic stallVal, input logic rstVal);
      CycleRec rec;
      logic    take;
      logic    dutWait;
      @(posedge clk);
      #1;
      take = 1'b0;
      if (inst_flush && $urandom_range(0, 1) == 1) respCnt = 0;
      if (staleCnt > 0) begin
         staleCnt--;
         if (staleCnt == 0) get_inst = 1'b0;
      end
      if (respCnt > 0) begin
         respCnt--;
         if (respCnt == 0) begin
            get_inst   = 1'b1;
            inst_pc_in = respAddr;
            inst_in    = memWord(respAddr);
            staleCnt   = 0;
         end
      end
      mem_busy = ($urandom_range(0, 3) == 0);
      if (rstVal) begin
         reqSeen = 1'b0;
         respCnt = 0;
      end else if (if_req) begin
         if (!reqSeen) begin
            reqSeen   = 1'b1;
            takeDelay = $urandom_range(0, 3);
         end
         if (takeDelay > 0) takeDelay--;
         else if (!mem_busy) take = 1'b1;
      end else begin
         reqSeen = 1'b0;
      end
      if (take) begin
         respAddr = if_addr;
         respCnt  = $urandom_range(1, 4);
         staleCnt = $urandom_range(0, 2);
         if (staleCnt == 0) get_inst = 1'b0;
      end
      mem_take_if  = take;
      jump_in      = doJump;
      jump_addr_in = target;
      stall_in     = stallVal;
      rst          = rstVal;

      // A flush is owed whenever a jump meets a fetch the controller has accepted
      // but whose matching response has not yet been presented.
      dutWait      = outstanding;
      rec.expFlush = !rstVal && doJump && (take || dutWait);
      if (rstVal) begin
         outstanding = 1'b0;
      end else begin
         if (dutWait && (doJump || (get_inst && inst_pc_in[31:2] == outAddr[31:2])))
            outstanding = 1'b0;
         if (take) begin
            outstanding = !doJump;
            outAddr     = if_addr;
         end
      end
      rec.rstEv  = rstVal;
      rec.jump   = doJump;
      rec.target = target;
      rec.stall  = stallVal;
      recQ.push_back(rec);
   endtask

   // Scoreboard monitor: each cycle's stimulus record is applied after the
   // outputs of that cycle are checked, since those were decided one cycle earlier.
   logic [31:0] expPc = ResetPc;
   CycleRec     prevRec;
   logic        havePrev = 1'b0;
   int          deliverCount = 0;
   logic [31:0] watchPc = 32'hFFFF_FFFF;
   logic        seenWatch = 1'b0;

   always @(negedge clk) begin
      CycleRec cur;
      if (havePrev) begin
         checkOutput("inst_flush", 32'(inst_flush), 32'(prevRec.expFlush));
         if (prevRec.rstEv) begin
            checkOutput("reset if_req", 32'(if_req), 32'd0);
            checkOutput("reset if_addr", if_addr, 32'd0);
            checkOutput("reset if_pc", if_pc, 32'd0);
            checkOutput("reset if_inst", if_inst, 32'd0);
         end
         if (prevRec.jump || prevRec.rstEv || prevRec.stall)
            checkOutput("if_valid suppressed", 32'(if_valid), 32'd0);
         if (if_valid) begin
            checkOutput("if_pc", if_pc, expPc);
            checkOutput("if_inst", if_inst, memWord(expPc));
            deliverCount++;
            if (expPc == watchPc) seenWatch = 1'b1;
            expPc = expPc + 32'd4;
         end
         if (if_req) checkOutput("if_addr", if_addr, expPc);
      end
      if (recQ.size() > 0) begin
         cur = recQ.pop_front();
         if (cur.rstEv) expPc = ResetPc;
         else if (cur.jump) expPc = cur.target;
         prevRec  = cur;
         havePrev = 1'b1;
      end else begin
         havePrev = 1'b0;
      end
   end

   logic [31:0] tgt;
   logic        vals [5];
   logic        reqs [5];

   initial begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("if_req held low in reset", 32'(if_req), 32'd0);
      checkOutput("if_valid in reset", 32'(if_valid), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("first if_req", 32'(if_req), 32'd1);
      checkOutput("first if_addr", if_addr, ResetPc);

      for (int c = 0; c < 3000; c++) begin
         logic doJump;
         logic rstVal;
         int   r;
         r = $urandom_range(0, 9);
         if (r < 6) tgt = {23'd0, 7'($urandom_range(0, 31)), 2'b00};
         else if (r < 9) tgt = 32'h1000_0000 | {23'd0, 7'($urandom_range(0, 31)), 2'b00};
         else tgt = 32'hFFFF_FFF8;
         doJump = ($urandom_range(0, 99) < 6);
         rstVal = (c >= 1500 && c < 1502);
         if (rstVal) doJump = 1'b0;
         applyStimulus(doJump, tgt, ($urandom_range(0, 99) < 25), rstVal);
      end

      // Fill 0x200..0x20C, then loop back: four hits must stream with no request.
      seenWatch = 1'b0;
      watchPc   = 32'h0000_020C;
      applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0);
      for (int n = 0; n < 400 && !seenWatch; n++)
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("fill 0x200-0x20C", 32'(seenWatch), 32'd1);
      applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         @(negedge clk);
         vals[i] = if_valid;
         reqs[i] = if_req;
      end
      checkOutput("loop no valid after jump", 32'(vals[0]), 32'd0);
      for (int i = 1; i < 5; i++)
         checkOutput("loop hit streams", 32'(vals[i]), 32'd1);
      for (int i = 0; i < 5; i++)
         checkOutput("loop if_req low", 32'(reqs[i]), 32'd0);

      for (int i = 0; i < 30; i++)
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("delivery progress", 32'(deliverCount >= 200), 32'd1);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
